// File: rtl/sdram_frame_arbiter_if.sv
// Bundle of frame-control, FIFO-level and SDRAM command signals between the
// frame arbiter and its surroundings (pattern generator, VGA read FIFO, SDRAM
// controller command port).
//   master : the arbiter side (drives cmd_*, wr_frame_done, front_sel, busy)
//   slave  : the environment side (drives frame/vsync pulses, FIFO levels,
//            cmd_ready and burst_done)
interface sdram_frame_arbiter_if;
    logic        frame_start_i;
    logic        vsync_i;
    logic [10:0] wr_fifo_cnt;
    logic [10:0] rd_fifo_cnt;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [23:0] cmd_addr;
    logic [8:0]  cmd_len;
    logic        burst_done;
    logic        wr_frame_done;
    logic        front_sel;
    logic        busy;

    modport master (
        input  frame_start_i, vsync_i, wr_fifo_cnt, rd_fifo_cnt,
        input  cmd_ready, burst_done,
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_frame_done, front_sel, busy
    );

    modport slave (
        output frame_start_i, vsync_i, wr_fifo_cnt, rd_fifo_cnt,
        output cmd_ready, burst_done,
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_frame_done, front_sel, busy
    );
endinterface

// File: rtl/sdram_frame_arbiter.sv
// SDRAM burst scheduler for a double-buffered frame store. Arbitrates between
// the frame writer (write FIFO -> SDRAM back buffer) and the display reader
// (SDRAM front buffer -> read FIFO), one burst command outstanding at a time,
// and swaps front/back buffers on the vsync following a completed frame.
// Ports:
//   clk  - system clock
//   rst  - asynchronous reset, active-high
//   bus  - sdram_frame_arbiter_if.master: frame_start_i/vsync_i pulses,
//          wr/rd FIFO fill levels, cmd_valid/ready/write/addr/len command
//          port, burst_done completion pulse, wr_frame_done pulse,
//          front_sel (displayed buffer) and busy status.
module sdram_frame_arbiter #(
    parameter int unsigned FRAME_WORDS  = 786432,
    parameter int unsigned BURST_LEN    = 256,
    parameter int unsigned FIFO_DEPTH   = 1024,
    parameter int unsigned RD_LOW_WATER = 256,
    parameter logic [23:0] FB0_BASE     = 24'h000000,
    parameter logic [23:0] FB1_BASE     = 24'h100000
) (
    input  logic                  clk,
    input  logic                  rst,
    sdram_frame_arbiter_if.master bus
);
    localparam logic [23:0] FW    = 24'(FRAME_WORDS);
    localparam logic [23:0] BL    = 24'(BURST_LEN);
    localparam logic [10:0] LOW_W = 11'(RD_LOW_WATER);
    localparam logic [10:0] BG_W  = 11'(FIFO_DEPTH - BURST_LEN);

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_CMD, S_WAIT} state_t;

    state_t      state, state_nxt;
    logic        wr_active, swap_pend, vsync_pend;
    logic [23:0] wr_ptr, rd_ptr;
    logic        cmd_write_q;
    logic [23:0] cmd_addr_q;
    logic [8:0]  cmd_len_q;
    logic        wr_frame_done_q, front_sel_q;

    logic [23:0] wr_rem, rd_rem, wr_sum, rd_sum;
    logic [8:0]  wr_len, rd_len;
    logic        urgent, wr_req, bg_req, any_req, pick_write;
    logic        burst_end, rd_inflight;

    // Request evaluation and pointer arithmetic
    always_comb begin
        wr_rem     = FW - wr_ptr;
        rd_rem     = FW - rd_ptr;
        wr_len     = (wr_rem < BL) ? wr_rem[8:0] : BL[8:0];
        rd_len     = (rd_rem < BL) ? rd_rem[8:0] : BL[8:0];
        urgent     = bus.rd_fifo_cnt < LOW_W;
        wr_req     = wr_active && (bus.wr_fifo_cnt >= {2'b00, wr_len});
        bg_req     = bus.rd_fifo_cnt <= BG_W;
        any_req    = urgent || wr_req || bg_req;
        pick_write = !urgent && wr_req;
        wr_sum     = wr_ptr + {15'd0, cmd_len_q};
        rd_sum     = rd_ptr + {15'd0, cmd_len_q};
        burst_end  = (state == S_WAIT) && bus.burst_done;
        // A read already chosen in ARB counts as in flight: its address was
        // taken from the old rd_ptr, so a vsync there must also be deferred.
        rd_inflight = ((state == S_ARB) && any_req && !pick_write) ||
                      (((state == S_CMD) || (state == S_WAIT)) && !cmd_write_q);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (any_req) state_nxt = S_ARB;
            S_ARB:   state_nxt = any_req ? S_CMD : S_IDLE;
            S_CMD:   if (bus.cmd_ready) state_nxt = S_WAIT;
            S_WAIT:  if (bus.burst_done) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.cmd_valid     = (state == S_CMD);
        bus.busy          = (state != S_IDLE);
        bus.cmd_write     = cmd_write_q;
        bus.cmd_addr      = cmd_addr_q;
        bus.cmd_len       = cmd_len_q;
        bus.wr_frame_done = wr_frame_done_q;
        bus.front_sel     = front_sel_q;
    end

    // Command registers, pointers and buffer-swap bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_write_q     <= 1'b0;
            cmd_addr_q      <= '0;
            cmd_len_q       <= '0;
            wr_frame_done_q <= 1'b0;
            front_sel_q     <= 1'b0;
            wr_active       <= 1'b0;
            swap_pend       <= 1'b0;
            vsync_pend      <= 1'b0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
        end else begin
            wr_frame_done_q <= 1'b0;

            if ((state == S_ARB) && any_req) begin
                cmd_write_q <= pick_write;
                if (pick_write) begin
                    cmd_addr_q <= (front_sel_q ? FB0_BASE : FB1_BASE) + wr_ptr;
                    cmd_len_q  <= wr_len;
                end else begin
                    cmd_addr_q <= (front_sel_q ? FB1_BASE : FB0_BASE) + rd_ptr;
                    cmd_len_q  <= rd_len;
                end
            end

            if (bus.frame_start_i && !wr_active && !swap_pend) begin
                wr_active <= 1'b1;
                wr_ptr    <= '0;
            end

            // Final write burst: a coincident vsync swaps at once instead of
            // leaving the swap pending for the next frame boundary.
            if (burst_end && cmd_write_q) begin
                wr_ptr <= wr_sum;
                if (wr_sum == FW) begin
                    wr_frame_done_q <= 1'b1;
                    wr_active       <= 1'b0;
                    if (bus.vsync_i) front_sel_q <= ~front_sel_q;
                    else             swap_pend   <= 1'b1;
                end
            end

            if (burst_end && !cmd_write_q) begin
                vsync_pend <= 1'b0;
                if (bus.vsync_i || vsync_pend) begin
                    rd_ptr <= '0;
                    if (swap_pend) begin
                        front_sel_q <= ~front_sel_q;
                        swap_pend   <= 1'b0;
                    end
                end else begin
                    rd_ptr <= (rd_sum == FW) ? '0 : rd_sum;
                end
            end else if (bus.vsync_i) begin
                if (rd_inflight) begin
                    vsync_pend <= 1'b1;
                end else begin
                    rd_ptr <= '0;
                    if (swap_pend) begin
                        front_sel_q <= ~front_sel_q;
                        swap_pend   <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Self-checking bench for sdram_frame_arbiter (FRAME_WORDS reduced to 600).
module tb_sdram_frame_arbiter;
    localparam int FW = 600;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    // Reference state
    int m_front, m_wr_act, m_swap, m_wr_ptr, m_rd_ptr;

    sdram_frame_arbiter_if bus_if();

    sdram_frame_arbiter #(.FRAME_WORDS(FW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic quiet();
        bus_if.rd_fifo_cnt = 11'd800;
        bus_if.wr_fifo_cnt = 11'd0;
    endtask

    function automatic int blen(input int p);
        return (FW - p < 256) ? FW - p : 256;
    endfunction

    task automatic model_reset();
        m_front = 0; m_wr_act = 0; m_swap = 0; m_wr_ptr = 0; m_rd_ptr = 0;
    endtask

    task automatic vs_effect();
        m_rd_ptr = 0;
        if (m_swap != 0) begin
            m_front ^= 1;
            m_swap = 0;
        end
    endtask

    task automatic pulse_frame_start();
        bus_if.frame_start_i = 1'b1;
        step();
        bus_if.frame_start_i = 1'b0;
        if (m_wr_act == 0 && m_swap == 0) begin
            m_wr_act = 1;
            m_wr_ptr = 0;
        end
    endtask

    task automatic pulse_vsync_idle();
        bus_if.vsync_i = 1'b1;
        step();
        bus_if.vsync_i = 1'b0;
        vs_effect();
        check("vsync_front", bus_if.front_sel, m_front);
    endtask

    // One complete transaction. vs_mode: 0 none, 1 vsync while in WAIT,
    // 2 vsync in the same cycle as burst_done.
    task automatic burst(input int rd, input int wr, input int rdy_dly,
                         input int done_dly, input int vs_mode, input bit stab);
        int  n, len, addr;
        bit  is_wr, fin;
        bus_if.rd_fifo_cnt = 11'(rd);
        bus_if.wr_fifo_cnt = 11'(wr);
        if (rd < 256)                                      is_wr = 1'b0;
        else if (m_wr_act != 0 && wr >= blen(m_wr_ptr))    is_wr = 1'b1;
        else if (rd <= 768)                                is_wr = 1'b0;
        else begin
            repeat (3) step();
            check("no_request_busy", bus_if.busy, 0);
            quiet();
            return;
        end
        len  = is_wr ? blen(m_wr_ptr) : blen(m_rd_ptr);
        addr = is_wr ? ((m_front != 0 ? 'h000000 : 'h100000) + m_wr_ptr)
                     : ((m_front != 0 ? 'h100000 : 'h000000) + m_rd_ptr);

        step();
        check("arb_no_valid", bus_if.cmd_valid, 0);
        step();
        check("latency2_valid", bus_if.cmd_valid, 1);
        n = 0;
        while (bus_if.cmd_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) check("cmd_valid_timeout", n, 0);
        check("cmd_write", bus_if.cmd_write, is_wr);
        check("cmd_addr", bus_if.cmd_addr, addr);
        check("cmd_len", bus_if.cmd_len, len);

        for (int i = 0; i < rdy_dly; i++) begin
            step();
            if (stab) begin
                check("hold_valid", bus_if.cmd_valid, 1);
                check("hold_addr", bus_if.cmd_addr, addr);
                check("hold_len", bus_if.cmd_len, len);
            end
        end
        bus_if.cmd_ready = 1'b1;
        step();
        bus_if.cmd_ready = 1'b0;
        quiet();
        check("wait_no_valid", bus_if.cmd_valid, 0);
        check("wait_busy", bus_if.busy, 1);

        if (vs_mode == 1) begin
            bus_if.vsync_i = 1'b1;
            step();
            bus_if.vsync_i = 1'b0;
            if (is_wr) vs_effect();
        end
        repeat (done_dly) step();
        bus_if.burst_done = 1'b1;
        if (vs_mode == 2) bus_if.vsync_i = 1'b1;
        step();
        bus_if.burst_done = 1'b0;
        bus_if.vsync_i    = 1'b0;

        fin = 1'b0;
        if (is_wr) begin
            m_wr_ptr += len;
            if (m_wr_ptr == FW) begin
                fin = 1'b1;
                m_wr_act = 0;
                m_swap = 1;
            end
            if (vs_mode == 2) vs_effect();
        end else begin
            if (vs_mode != 0) vs_effect();
            else m_rd_ptr = (m_rd_ptr + len) % FW;
        end
        check("frame_done_pulse", bus_if.wr_frame_done, fin);
        check("front_sel", bus_if.front_sel, m_front);
        check("idle_after_done", bus_if.busy, 0);
        step();
        check("frame_done_clear", bus_if.wr_frame_done, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, bus_if.cmd_valid, 0);
        check({tag, "_write"}, bus_if.cmd_write, 0);
        check({tag, "_addr"}, bus_if.cmd_addr, 0);
        check({tag, "_len"}, bus_if.cmd_len, 0);
        check({tag, "_fdone"}, bus_if.wr_frame_done, 0);
        check({tag, "_front"}, bus_if.front_sel, 0);
        check({tag, "_busy"}, bus_if.busy, 0);
    endtask

    initial begin
        int rd, wr, vs, c;
        bus_if.frame_start_i = 1'b0;
        bus_if.vsync_i       = 1'b0;
        bus_if.cmd_ready     = 1'b0;
        bus_if.burst_done    = 1'b0;
        quiet();
        model_reset();
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // Sequential reads from FB0
        burst(0, 0, 0, 0, 0, 0);
        burst(0, 0, 1, 2, 0, 0);

        // Write into back buffer, urgent read wins over write
        pulse_frame_start();
        burst(600, 256, 1, 1, 0, 0);
        burst(100, 256, 0, 0, 0, 0);
        burst(800, 256, 2, 0, 0, 0);
        pulse_frame_start();
        burst(800, 100, 0, 3, 0, 0);
        pulse_frame_start();
        burst(800, 300, 0, 0, 0, 0);

        // Swap, then reads from FB1 and writes to FB0
        pulse_vsync_idle();
        burst(0, 0, 0, 0, 0, 0);
        pulse_frame_start();
        burst(800, 256, 0, 0, 0, 0);

        // vsync during a read burst, then coincident with the final write
        burst(0, 0, 0, 2, 1, 0);
        burst(0, 0, 0, 0, 0, 0);
        burst(800, 256, 0, 0, 0, 0);
        burst(800, 100, 0, 1, 2, 0);

        // Stray handshake pulses outside their states are ignored
        bus_if.burst_done = 1'b1;
        bus_if.cmd_ready  = 1'b1;
        step();
        bus_if.burst_done = 1'b0;
        bus_if.cmd_ready  = 1'b0;
        check("stray_busy", bus_if.busy, 0);

        for (int i = 0; i < 40; i++) begin
            c = $urandom_range(0, 9);
            if (c == 0) pulse_frame_start();
            else if (c == 1) pulse_vsync_idle();
            else if (c == 2) begin
                bus_if.burst_done = 1'b1;
                step();
                bus_if.burst_done = 1'b0;
            end
            c = $urandom_range(0, 2);
            rd = (c == 0) ? $urandom_range(0, 255)
               : (c == 1) ? $urandom_range(256, 768) : $urandom_range(769, 1024);
            wr = $urandom_range(0, 300);
            vs = $urandom_range(0, 5);
            vs = (vs == 4) ? 1 : (vs == 5) ? 2 : 0;
            burst(rd, wr, $urandom_range(0, 3), $urandom_range(0, 3), vs, 1'b0);
        end

        // Long stall in CMD keeps the command stable
        burst(0, 0, 10, 0, 0, 1'b1);

        // Reset while a burst is in WAIT
        bus_if.rd_fifo_cnt = 11'd0;
        step();
        step();
        bus_if.cmd_ready = 1'b1;
        step();
        bus_if.cmd_ready = 1'b0;
        quiet();
        check("pre_reset_busy", bus_if.busy, 1);
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        step();
        rst = 1'b0;
        model_reset();
        step();
        burst(0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
